// File: rtl/bridge_id_bank.sv
// bridge_id_bank: read-mostly identification bank on a simple word-addressed bus.
//
// Word map (W = addr[5:2]):
//   0..NUM_ID-1      constant ID words (ID_WORDS[W])
//   8                uptime[31:0]; a read also latches uptime[63:32] into the high shadow
//   9                uptime high-half shadow
//   10               read counter (saturating); any write clears it
//   12..12+NS-1      read/write scratch words
//   others           read as zero, writes ignored
//
// Ports:
//   clk           bus clock, the only clock
//   reset_n       asynchronous active-low reset
//   addr          byte address, only [5:2] decoded
//   rd / wr       single-cycle read / write strobes
//   wr_data       write data
//   rd_data       read data, held between deliveries
//   rd_data_valid one pulse per accepted read, READ_LATENCY cycles after rd
module bridge_id_bank #(
  parameter int unsigned NUM_ID          = 3,
  parameter logic [31:0] BUILD_DATE      = 32'h2024_0601,
  parameter logic [31:0] BUILD_TIME      = 32'h0012_3456,
  parameter logic [31:0] BUILD_UNIQUE_ID = 32'hB1D6_E001,
  parameter logic [31:0] ID_WORDS [8]    = '{BUILD_DATE, BUILD_TIME, BUILD_UNIQUE_ID,
                                             32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
  parameter int unsigned NUM_SCRATCH     = 2,
  parameter int unsigned READ_LATENCY    = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rd_data_valid
);

  // One bit per implemented word, so an index test needs no range comparison.
  localparam logic [7:0] IdMask      = 8'((1 << NUM_ID) - 1);
  localparam logic [3:0] ScratchMask = 4'((1 << NUM_SCRATCH) - 1);

  logic [3:0]  w;
  logic        id_hit;
  logic        scratch_hit;
  logic [31:0] rd_word;

  logic [63:0] uptime_q, uptime_d;
  logic [31:0] uptime_hi_q, uptime_hi_d;
  logic [31:0] rd_count_q, rd_count_d;
  logic [31:0] scratch_q [4];

  logic [READ_LATENCY-1:0] pipe_valid_q;
  logic [31:0]             pipe_data_q [READ_LATENCY];

  logic unused_addr;
  assign unused_addr = ^{addr[31:6], addr[1:0]};

  assign w           = addr[5:2];
  assign id_hit      = !w[3] && IdMask[w[2:0]];
  assign scratch_hit = (w[3:2] == 2'b11) && ScratchMask[w[1:0]];

  // Read mux works on current register values, so a same-cycle write is not visible.
  always_comb begin
    rd_word = '0;
    if (id_hit) begin
      rd_word = ID_WORDS[w[2:0]];
    end else begin
      case (w)
        4'd8:  rd_word = uptime_q[31:0];
        4'd9:  rd_word = uptime_hi_q;
        4'd10: rd_word = rd_count_q;
        4'd12, 4'd13, 4'd14, 4'd15: begin
          if (scratch_hit) rd_word = scratch_q[w[1:0]];
        end
        default: rd_word = '0;
      endcase
    end
  end

  always_comb begin
    uptime_d    = uptime_q + 64'd1;
    uptime_hi_d = uptime_hi_q;
    if (rd && (w == 4'd8)) uptime_hi_d = uptime_q[63:32];
    rd_count_d = rd_count_q;
    // Clear takes priority over a coincident read's increment.
    if (wr && (w == 4'd10)) begin
      rd_count_d = '0;
    end else if (rd && (rd_count_q != 32'hFFFF_FFFF)) begin
      rd_count_d = rd_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q    <= '0;
      uptime_hi_q <= '0;
      rd_count_q  <= '0;
    end else begin
      uptime_q    <= uptime_d;
      uptime_hi_q <= uptime_hi_d;
      rd_count_q  <= rd_count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr && scratch_hit && (w[1:0] == 2'(i))) scratch_q[i] <= wr_data;
      end
    end
  end

  // Data in each stage only moves with a valid beat, so the last stage holds
  // the most recently delivered word while the valid is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q[0] <= rd;
      if (rd) pipe_data_q[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        if (pipe_valid_q[i-1]) pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign rd_data       = pipe_data_q[READ_LATENCY-1];
  assign rd_data_valid = pipe_valid_q[READ_LATENCY-1];

endmodule

// File: tb/tb_bridge_id_bank.sv
module tb_bridge_id_bank;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  localparam logic [31:0] IdA0 = 32'h1111_0001;
  localparam logic [31:0] IdA1 = 32'h2222_0002;
  localparam logic [31:0] IdA2 = 32'h3333_0003;
  localparam logic [31:0] IdA3 = 32'h4444_0004;
  localparam logic [31:0] IdB0 = 32'h5A5A_0B00;
  localparam logic [31:0] IdB2 = 32'h5A5A_0B02;

  logic        clk;
  logic [31:0] addr, wr_data;
  logic        rst_a, rst_b, rst_c;
  logic        rd_a, rd_b, rd_c, wr_a, wr_b, wr_c;
  logic [31:0] rdd_a, rdd_b, rdd_c;
  logic        vld_a, vld_b, vld_c;

  exp_t        q_a[$], q_b[$], q_c[$];
  logic [31:0] last_d [3];
  int          cyc, rel, tests, fails;

  // A: latency 2, two scratch words, NUM_ID 3 with a non-zero fourth entry.
  bridge_id_bank #(
    .NUM_ID(3), .NUM_SCRATCH(2), .READ_LATENCY(2),
    .ID_WORDS('{IdA0, IdA1, IdA2, IdA3, 32'h0, 32'h0, 32'h0, 32'h0})
  ) dut_a (
    .clk(clk), .reset_n(rst_a), .addr(addr), .rd(rd_a), .wr(wr_a), .wr_data(wr_data),
    .rd_data(rdd_a), .rd_data_valid(vld_a)
  );

  // B: latency 3, used for reset-in-flight.
  bridge_id_bank #(
    .NUM_ID(3), .NUM_SCRATCH(2), .READ_LATENCY(3),
    .ID_WORDS('{IdB0, 32'h5A5A_0B01, IdB2, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0})
  ) dut_b (
    .clk(clk), .reset_n(rst_b), .addr(addr), .rd(rd_b), .wr(wr_b), .wr_data(wr_data),
    .rd_data(rdd_b), .rd_data_valid(vld_b)
  );

  // C: no scratch words, latency 1.
  bridge_id_bank #(
    .NUM_SCRATCH(0), .READ_LATENCY(1)
  ) dut_c (
    .clk(clk), .reset_n(rst_c), .addr(addr), .rd(rd_c), .wr(wr_c), .wr_data(wr_data),
    .rd_data(rdd_c), .rd_data_valid(vld_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_port(input int k, input logic v, input logic [31:0] d);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '{data: 32'h0, due: 0};
    case (k)
      0: if (q_a.size() > 0) begin e = q_a[0]; have = 1'b1; end
      1: if (q_b.size() > 0) begin e = q_b[0]; have = 1'b1; end
      default: if (q_c.size() > 0) begin e = q_c[0]; have = 1'b1; end
    endcase
    if (v === 1'b1) begin
      tests++;
      assert (have) else begin
        fails++;
        $error("FAIL valid_without_rd[%0d] observed valid=1 expected valid=0 cyc=%0d", k, cyc);
      end
      if (have) begin
        case (k)
          0: void'(q_a.pop_front());
          1: void'(q_b.pop_front());
          default: void'(q_c.pop_front());
        endcase
        last_d[k] = e.data;
        tests++;
        assert (d === e.data) else begin
          fails++;
          $error("FAIL rd_data[%0d] observed=%h expected=%h cyc=%0d", k, d, e.data, cyc);
        end
        tests++;
        assert (cyc === e.due) else begin
          fails++;
          $error("FAIL valid_timing[%0d] observed cyc=%0d expected cyc=%0d", k, cyc, e.due);
        end
      end
    end else begin
      if (have && (cyc >= e.due)) begin
        tests++;
        assert (v === 1'b1) else begin
          fails++;
          $error("FAIL missing_valid[%0d] observed valid=%b expected valid=1 cyc=%0d", k, v, cyc);
        end
        case (k)
          0: void'(q_a.pop_front());
          1: void'(q_b.pop_front());
          default: void'(q_c.pop_front());
        endcase
      end
      tests++;
      assert (d === last_d[k]) else begin
        fails++;
        $error("FAIL hold_data[%0d] observed=%h expected=%h cyc=%0d", k, d, last_d[k], cyc);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
    check_port(0, vld_a, rdd_a);
    check_port(1, vld_b, rdd_b);
    check_port(2, vld_c, rdd_c);
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0;
    wr_a = 1'b0; wr_b = 1'b0; wr_c = 1'b0;
  endtask

  task automatic rd_do(input int k, input logic [3:0] w, input logic [31:0] e);
    addr = {26'd0, w, 2'b00};
    case (k)
      0: begin rd_a = 1'b1; q_a.push_back('{data: e, due: cyc + 2}); end
      1: begin rd_b = 1'b1; q_b.push_back('{data: e, due: cyc + 3}); end
      default: begin rd_c = 1'b1; q_c.push_back('{data: e, due: cyc + 1}); end
    endcase
  endtask

  task automatic wr_do(input int k, input logic [3:0] w, input logic [31:0] data);
    addr    = {26'd0, w, 2'b00};
    wr_data = data;
    case (k)
      0: wr_a = 1'b1;
      1: wr_b = 1'b1;
      default: wr_c = 1'b1;
    endcase
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic v);
    tests++;
    assert ((d === 32'h0) && (v === 1'b0)) else begin
      fails++;
      $error("FAIL %s observed data=%h valid=%b expected data=0 valid=0", tag, d, v);
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; rel = 0;
    for (int i = 0; i < 3; i++) last_d[i] = 32'h0;
    addr = '0; wr_data = '0;
    rd_a = 0; rd_b = 0; rd_c = 0; wr_a = 0; wr_b = 0; wr_c = 0;
    rst_a = 0; rst_b = 0; rst_c = 0;

    repeat (3) tick();
    check_out("reset_a", rdd_a, vld_a);
    check_out("reset_b", rdd_b, vld_b);
    check_out("reset_c", rdd_c, vld_c);

    // Release; a read in the very first cycle sees uptime 0.
    rst_a = 1; rst_b = 1; rst_c = 1;
    rel = cyc;
    rd_do(0, 4'd8, 32'h0);
    tick();

    // Back-to-back ID reads, then unmapped / beyond-NUM_ID words.
    rd_do(0, 4'd0, IdA0); tick();
    rd_do(0, 4'd1, IdA1); tick();
    rd_do(0, 4'd2, IdA2); tick();
    rd_do(0, 4'd3, 32'h0); tick();
    rd_do(0, 4'd7, 32'h0); tick();
    rd_do(0, 4'd11, 32'h0); tick();

    // Uptime tracks cycles since release; high shadow still 0.
    rd_do(0, 4'd8, 32'(cyc - rel)); tick();
    rd_do(0, 4'd9, 32'h0); tick();

    // Carry across the low half does not disturb the latched high half.
    force dut_a.uptime_q = 64'h0000_0001_FFFF_FFFF;
    rd_do(0, 4'd8, 32'hFFFF_FFFF);
    tick();
    release dut_a.uptime_q;
    tick();
    tick();
    rd_do(0, 4'd9, 32'h0000_0001); tick();

    // Scratch: same-cycle rd returns old value; the write lands.
    wr_do(0, 4'd12, 32'hA5A5_5A5A);
    rd_do(0, 4'd12, 32'h0);
    tick();
    rd_do(0, 4'd12, 32'hA5A5_5A5A); tick();
    wr_do(0, 4'd13, 32'h1234_5678); tick();
    rd_do(0, 4'd13, 32'h1234_5678); tick();
    rd_do(0, 4'd12, 32'hA5A5_5A5A); tick();
    wr_do(0, 4'd14, 32'hDEAD_BEEF); tick();
    rd_do(0, 4'd14, 32'h0); tick();
    wr_do(0, 4'd0, 32'hFFFF_FFFF); tick();
    rd_do(0, 4'd0, IdA0); tick();

    // Read counter: clear, five reads, then W=10 reads 5.
    wr_do(0, 4'd10, 32'h0000_1234); tick();
    for (int i = 0; i < 5; i++) begin
      rd_do(0, 4'd1, IdA1); tick();
    end
    rd_do(0, 4'd10, 32'd5); tick();
    // Clear wins over the coincident read's increment.
    wr_do(0, 4'd10, 32'hFFFF_FFFF);
    rd_do(0, 4'd10, 32'd6);
    tick();
    rd_do(0, 4'd10, 32'd0); tick();

    // Saturation.
    force dut_a.rd_count_q = 32'hFFFF_FFFE;
    tick();
    release dut_a.rd_count_q;
    for (int i = 0; i < 3; i++) begin
      rd_do(0, 4'd0, IdA0); tick();
    end
    rd_do(0, 4'd10, 32'hFFFF_FFFF); tick();
    rd_do(0, 4'd10, 32'hFFFF_FFFF); tick();

    // In-flight read on B is discarded by reset (no scoreboard entry).
    addr = 32'h0;
    rd_b = 1'b1;
    tick();
    rst_b = 0;
    last_d[1] = 32'h0;
    tick();
    check_out("reset_inflight_b", rdd_b, vld_b);
    tick();
    rst_b = 1;
    repeat (5) tick();
    check_out("post_reset_b", rdd_b, vld_b);
    rd_do(1, 4'd2, IdB2); tick();

    // C has no scratch: write ignored, read still returns a valid zero.
    wr_do(2, 4'd12, 32'hCAFE_F00D); tick();
    rd_do(2, 4'd12, 32'h0); tick();
    rd_do(2, 4'd13, 32'h0); tick();

    repeat (6) tick();
    tests++;
    assert ((q_a.size() + q_b.size() + q_c.size()) === 0) else begin
      fails++;
      $error("FAIL drain observed pending=%0d expected pending=0",
             q_a.size() + q_b.size() + q_c.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
